// File: rtl/wavegen_pkg.sv
// Shared widths, DAC command nibbles and SPI transmitter state encoding
// for the waveform generator datapath.
package wavegen_pkg;
  localparam int SAMPLE_W = 12;
  localparam int FRAME_W  = 16;
  localparam int CMD_W    = 4;

  localparam logic [CMD_W-1:0] CMD_WRITE_UPDATE_A = 4'b0011;
  localparam logic [CMD_W-1:0] CMD_WRITE_UPDATE_B = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_GAP
  } dac_state_t;
endpackage

// File: rtl/dac_sclk_gen.sv
// SCLK timing for the DAC serializer: half-period ticks, rise/fall strobes
// and detection of the final (16th) falling edge of a frame.
module dac_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_shift,
  output logic o_half_tick,
  output logic o_rise_tick,
  output logic o_fall_tick,
  output logic o_last_fall
);
  localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

  logic [7:0] r_cnt;
  logic       r_phase;
  logic [4:0] r_edges;

  assign o_half_tick = i_en && (r_cnt == 8'd0);
  assign o_rise_tick = o_half_tick && i_shift && !r_phase;
  assign o_fall_tick = o_half_tick && i_shift && r_phase;
  assign o_last_fall = o_fall_tick && (r_edges == 5'd16);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= RELOAD;
      r_phase <= 1'b0;
      r_edges <= 5'd0;
    end else begin
      if (!i_en || r_cnt == 8'd0) r_cnt <= RELOAD;
      else                        r_cnt <= r_cnt - 8'd1;
      // phase mirrors the SCLK level; it only runs while shifting
      if (!i_shift)         r_phase <= 1'b0;
      else if (o_half_tick) r_phase <= ~r_phase;
      if (!i_shift)         r_edges <= 5'd0;
      else if (o_rise_tick) r_edges <= r_edges + 5'd1;
    end
  end
endmodule

// File: rtl/dac_spi_tx.sv
// Serializes 12-bit samples to an SPI DAC as {CMD, sample} 16-bit frames,
// with a single-entry pending buffer and frame/overrun counters.
module dac_spi_tx
  import wavegen_pkg::*;
#(
  parameter int                CLK_DIV = 4,
  parameter logic [CMD_W-1:0]  CMD     = CMD_WRITE_UPDATE_A,
  parameter int                CS_GAP  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                sample_valid,
  input  logic                enable,
  output logic                dac_cs_n,
  output logic                dac_sclk,
  output logic                dac_mosi,
  output logic                busy,
  output logic [15:0]         frames_sent,
  output logic [15:0]         overrun_count
);
  dac_state_t          r_state;
  logic [SAMPLE_W-1:0] r_pend_data;
  logic                r_pend_full;
  logic [FRAME_W-1:0]  r_shreg;
  logic [7:0]          r_gap_cnt;
  logic                w_start, w_half_tick, w_rise_tick, w_fall_tick, w_last_fall;
  logic                w_sclk_en, w_shift;

  assign w_start   = (r_state == ST_IDLE) && enable && r_pend_full;
  assign w_sclk_en = (r_state == ST_SETUP) || (r_state == ST_SHIFT);
  assign w_shift   = (r_state == ST_SHIFT);

  dac_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
    .clk         (clk),
    .reset       (reset),
    .i_en        (w_sclk_en),
    .i_shift     (w_shift),
    .o_half_tick (w_half_tick),
    .o_rise_tick (w_rise_tick),
    .o_fall_tick (w_fall_tick),
    .o_last_fall (w_last_fall)
  );

  // A strobe on the consume cycle refills the buffer without counting an overrun
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend_data   <= '0;
      r_pend_full   <= 1'b0;
      overrun_count <= 16'd0;
    end else if (sample_valid) begin
      r_pend_data <= sample;
      r_pend_full <= 1'b1;
      if (r_pend_full && !w_start && overrun_count != 16'hFFFF)
        overrun_count <= overrun_count + 16'd1;
    end else if (w_start) begin
      r_pend_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_shreg     <= '0;
      r_gap_cnt   <= 8'd0;
      dac_cs_n    <= 1'b1;
      dac_sclk    <= 1'b0;
      dac_mosi    <= 1'b0;
      busy        <= 1'b0;
      frames_sent <= 16'd0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_start) begin
          r_shreg  <= {CMD, r_pend_data};
          dac_cs_n <= 1'b0;
          dac_mosi <= CMD[CMD_W-1];
          busy     <= 1'b1;
          r_state  <= ST_SETUP;
        end
        ST_SETUP: if (w_half_tick) r_state <= ST_SHIFT;
        ST_SHIFT: begin
          if (w_rise_tick) dac_sclk <= 1'b1;
          if (w_last_fall) begin
            dac_sclk    <= 1'b0;
            dac_cs_n    <= 1'b1;
            dac_mosi    <= 1'b0;
            frames_sent <= frames_sent + 16'd1;
            r_gap_cnt   <= 8'(CS_GAP - 1);
            r_state     <= ST_GAP;
          end else if (w_fall_tick) begin
            dac_sclk <= 1'b0;
            r_shreg  <= r_shreg << 1;
            dac_mosi <= r_shreg[FRAME_W-2];
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == 8'd0) begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
          end else begin
            r_gap_cnt <= r_gap_cnt - 8'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule
